// File: rtl/issue_queue.sv
// Issue queue for one functional-unit class: dispatch allocation into the
// lowest free entries, writeback wakeup with same-cycle bypass, oldest-ready
// selection relative to the ROB head, and a registered valid/ready issue port.
module issue_queue #(
   parameter int DEPTH  = 8,
   parameter int N_DISP = 3,
   parameter int N_WB   = 3,
   parameter int PREG_W = 5,
   parameter int ROB_W  = 5,
   parameter int TYPE_W = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic [TYPE_W-1:0]          type_ref,
   input  logic                       disp_en,
   input  logic [N_DISP-1:0]          disp_valid,
   input  logic [N_DISP*TYPE_W-1:0]   disp_type,
   input  logic [N_DISP*PREG_W-1:0]   disp_pa,
   input  logic [N_DISP*PREG_W-1:0]   disp_pb,
   input  logic [N_DISP*PREG_W-1:0]   disp_pw,
   input  logic [N_DISP-1:0]          disp_ra,
   input  logic [N_DISP-1:0]          disp_rb,
   input  logic [N_DISP*ROB_W-1:0]    disp_rob,
   output logic                       full_rs,
   output logic [$clog2(DEPTH+1)-1:0] free_cnt,
   input  logic [N_WB-1:0]            wb_valid,
   input  logic [N_WB*PREG_W-1:0]     wb_preg,
   input  logic [ROB_W-1:0]           ptr_old,
   output logic                       iss_valid,
   input  logic                       iss_ready,
   output logic [PREG_W-1:0]          iss_pa,
   output logic [PREG_W-1:0]          iss_pb,
   output logic [PREG_W-1:0]          iss_pw,
   output logic [ROB_W-1:0]           iss_rob
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0]  vld, rdy_a, rdy_b;
   logic [PREG_W-1:0] pa [DEPTH];
   logic [PREG_W-1:0] pb [DEPTH];
   logic [PREG_W-1:0] pw [DEPTH];
   logic [ROB_W-1:0]  rob [DEPTH];

   logic              accept;
   logic [N_DISP-1:0] port_wr;
   logic [IDX_W-1:0]  port_slot [N_DISP];

   logic [DEPTH-1:0]  ent_wr, ent_ra, ent_rb;
   logic [PREG_W-1:0] ent_pa [DEPTH];
   logic [PREG_W-1:0] ent_pb [DEPTH];
   logic [PREG_W-1:0] ent_pw [DEPTH];
   logic [ROB_W-1:0]  ent_rob [DEPTH];

   logic [DEPTH-1:0]       cand;
   logic [DEPTH*ROB_W-1:0] ages;
   logic                   sel_found;
   logic [IDX_W-1:0]       sel_idx;
   logic                   issue_go;

   function automatic logic wb_hit(input logic [PREG_W-1:0] tag);
      logic hit;
      hit = 1'b0;
      for (int c = 0; c < N_WB; c++)
         if (wb_valid[c] && (wb_preg[c*PREG_W +: PREG_W] == tag)) hit = 1'b1;
      return hit;
   endfunction

   function automatic int count_below(input logic [N_DISP-1:0] wr, input int lim);
      int n;
      n = 0;
      for (int i = 0; i < N_DISP; i++)
         if (i < lim && wr[i]) n++;
      return n;
   endfunction

   function automatic logic [IDX_W-1:0] nth_free(input logic [DEPTH-1:0] busy, input int rank);
      int               seen;
      logic [IDX_W-1:0] r;
      seen = 0;
      r    = '0;
      for (int e = 0; e < DEPTH; e++) begin
         if (!busy[e]) begin
            if (seen == rank) r = IDX_W'(e);
            seen++;
         end
      end
      return r;
   endfunction

   // Binary comparator tree over a heap layout; the left child always covers
   // lower indices, so equal ages resolve to the lowest entry.
   function automatic logic [IDX_W:0] pick_oldest(input logic [DEPTH-1:0] c,
                                                  input logic [DEPTH*ROB_W-1:0] a);
      logic             nv [2*DEPTH];
      logic [IDX_W-1:0] ni [2*DEPTH];
      logic [ROB_W-1:0] na [2*DEPTH];
      for (int n = 0; n < 2*DEPTH; n++) begin
         nv[n] = 1'b0;
         ni[n] = '0;
         na[n] = '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
         nv[DEPTH+i] = c[i];
         ni[DEPTH+i] = IDX_W'(i);
         na[DEPTH+i] = a[i*ROB_W +: ROB_W];
      end
      for (int n = DEPTH-1; n >= 1; n--) begin
         if (nv[2*n] && (!nv[2*n+1] || (na[2*n] <= na[2*n+1]))) begin
            nv[n] = 1'b1;
            ni[n] = ni[2*n];
            na[n] = na[2*n];
         end else begin
            nv[n] = nv[2*n+1];
            ni[n] = ni[2*n+1];
            na[n] = na[2*n+1];
         end
      end
      return {nv[1], ni[1]};
   endfunction

   assign free_cnt = CNT_W'(DEPTH - $countones(vld));
   assign full_rs  = (free_cnt < CNT_W'(N_DISP));
   assign accept   = disp_en && !full_rs && !flush;

   // Ports that write an entry this cycle and the free slot each one takes
   always_comb begin
      for (int i = 0; i < N_DISP; i++) begin
         port_wr[i] = accept && disp_valid[i] && (disp_type[i*TYPE_W +: TYPE_W] == type_ref);
      end
   end

   // Rank among accepted ports selects the rank-th free entry of the current state
   always_comb begin
      for (int i = 0; i < N_DISP; i++) begin
         port_slot[i] = nth_free(vld, count_below(port_wr, i));
      end
   end

   // Scatter accepted port payloads onto their destination entries
   always_comb begin
      ent_wr = '0;
      ent_ra = '0;
      ent_rb = '0;
      for (int e = 0; e < DEPTH; e++) begin
         ent_pa[e]  = '0;
         ent_pb[e]  = '0;
         ent_pw[e]  = '0;
         ent_rob[e] = '0;
      end
      for (int i = 0; i < N_DISP; i++) begin
         if (port_wr[i]) begin
            ent_wr[port_slot[i]]  = 1'b1;
            ent_ra[port_slot[i]]  = disp_ra[i];
            ent_rb[port_slot[i]]  = disp_rb[i];
            ent_pa[port_slot[i]]  = disp_pa[i*PREG_W +: PREG_W];
            ent_pb[port_slot[i]]  = disp_pb[i*PREG_W +: PREG_W];
            ent_pw[port_slot[i]]  = disp_pw[i*PREG_W +: PREG_W];
            ent_rob[port_slot[i]] = disp_rob[i*ROB_W +: ROB_W];
         end
      end
   end

   // Ready candidates and their modular age from the ROB head
   always_comb begin
      for (int e = 0; e < DEPTH; e++) begin
         cand[e]                  = vld[e] & rdy_a[e] & rdy_b[e];
         ages[e*ROB_W +: ROB_W]   = rob[e] - ptr_old;
      end
   end

   assign {sel_found, sel_idx} = pick_oldest(cand, ages);
   assign issue_go = !flush && (!iss_valid || iss_ready) && sel_found;

   // Entry array: flush, then dispatch writes (with bypass), wakeup and issue release
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld   <= '0;
         rdy_a <= '0;
         rdy_b <= '0;
         for (int e = 0; e < DEPTH; e++) begin
            pa[e]  <= '0;
            pb[e]  <= '0;
            pw[e]  <= '0;
            rob[e] <= '0;
         end
      end else if (flush) begin
         vld   <= '0;
         rdy_a <= '0;
         rdy_b <= '0;
      end else begin
         for (int e = 0; e < DEPTH; e++) begin
            if (ent_wr[e]) begin
               vld[e]   <= 1'b1;
               rdy_a[e] <= ent_ra[e] | wb_hit(ent_pa[e]);
               rdy_b[e] <= ent_rb[e] | wb_hit(ent_pb[e]);
               pa[e]    <= ent_pa[e];
               pb[e]    <= ent_pb[e];
               pw[e]    <= ent_pw[e];
               rob[e]   <= ent_rob[e];
            end else if (vld[e]) begin
               if (issue_go && (sel_idx == IDX_W'(e))) vld[e] <= 1'b0;
               if (wb_hit(pa[e])) rdy_a[e] <= 1'b1;
               if (wb_hit(pb[e])) rdy_b[e] <= 1'b1;
            end
         end
      end
   end

   // Issue register: loads the selected entry whenever it is empty or being drained
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         iss_valid <= 1'b0;
         iss_pa    <= '0;
         iss_pb    <= '0;
         iss_pw    <= '0;
         iss_rob   <= '0;
      end else if (flush) begin
         iss_valid <= 1'b0;
      end else if (!iss_valid || iss_ready) begin
         iss_valid <= sel_found;
         if (sel_found) begin
            iss_pa  <= pa[sel_idx];
            iss_pb  <= pb[sel_idx];
            iss_pw  <= pw[sel_idx];
            iss_rob <= rob[sel_idx];
         end
      end
   end

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: a table of single-cycle steps with constant
// expectations, hand-written corner sequences, and a random run against a
// behavioural model of the queue.
module tb_issue_queue;
   localparam int DEPTH  = 8;
   localparam int N_DISP = 3;
   localparam int N_WB   = 3;
   localparam int PREG_W = 5;
   localparam int ROB_W  = 5;
   localparam int TYPE_W = 2;
   localparam logic [TYPE_W-1:0] TREF = 2'd1;

   logic                       clk = 1'b0;
   logic                       rst = 1'b1;
   logic                       flush;
   logic [TYPE_W-1:0]          type_ref;
   logic                       disp_en;
   logic [N_DISP-1:0]          disp_valid;
   logic [N_DISP*TYPE_W-1:0]   disp_type;
   logic [N_DISP*PREG_W-1:0]   disp_pa, disp_pb, disp_pw;
   logic [N_DISP-1:0]          disp_ra, disp_rb;
   logic [N_DISP*ROB_W-1:0]    disp_rob;
   logic                       full_rs;
   logic [$clog2(DEPTH+1)-1:0] free_cnt;
   logic [N_WB-1:0]            wb_valid;
   logic [N_WB*PREG_W-1:0]     wb_preg;
   logic [ROB_W-1:0]           ptr_old;
   logic                       iss_valid;
   logic                       iss_ready;
   logic [PREG_W-1:0]          iss_pa, iss_pb, iss_pw;
   logic [ROB_W-1:0]           iss_rob;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   issue_queue #(.DEPTH(DEPTH), .N_DISP(N_DISP), .N_WB(N_WB),
                 .PREG_W(PREG_W), .ROB_W(ROB_W), .TYPE_W(TYPE_W)) dut (
      .clk(clk), .rst(rst), .flush(flush), .type_ref(type_ref),
      .disp_en(disp_en), .disp_valid(disp_valid), .disp_type(disp_type),
      .disp_pa(disp_pa), .disp_pb(disp_pb), .disp_pw(disp_pw),
      .disp_ra(disp_ra), .disp_rb(disp_rb), .disp_rob(disp_rob),
      .full_rs(full_rs), .free_cnt(free_cnt),
      .wb_valid(wb_valid), .wb_preg(wb_preg), .ptr_old(ptr_old),
      .iss_valid(iss_valid), .iss_ready(iss_ready),
      .iss_pa(iss_pa), .iss_pb(iss_pb), .iss_pw(iss_pw), .iss_rob(iss_rob)
   );

   // ---------------------------------------------------------------- helpers
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic clear_in;
      disp_en    = 1'b0;
      disp_valid = '0;
      disp_type  = '0;
      disp_pa    = '0;
      disp_pb    = '0;
      disp_pw    = '0;
      disp_ra    = '0;
      disp_rb    = '0;
      disp_rob   = '0;
      wb_valid   = '0;
      wb_preg    = '0;
      iss_ready  = 1'b1;
      flush      = 1'b0;
   endtask

   task automatic set_port(input int p, input logic [4:0] a, input logic [4:0] b,
                           input logic [4:0] w, input logic [4:0] r,
                           input logic ra, input logic rb);
      disp_valid[p]              = 1'b1;
      disp_type[p*TYPE_W +: TYPE_W] = TREF;
      disp_pa[p*PREG_W +: PREG_W]   = a;
      disp_pb[p*PREG_W +: PREG_W]   = b;
      disp_pw[p*PREG_W +: PREG_W]   = w;
      disp_rob[p*ROB_W +: ROB_W]    = r;
      disp_ra[p]                 = ra;
      disp_rb[p]                 = rb;
   endtask

   task automatic set_wb(input int c, input logic [4:0] tag);
      wb_valid[c]                 = 1'b1;
      wb_preg[c*PREG_W +: PREG_W] = tag;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      clear_in;
      ptr_old = '0;
      #1 rst = 1'b0;
      #1;
      chk("rst_iss_valid", iss_valid, 0);
      chk("rst_iss_rob", iss_rob, 0);
      chk("rst_iss_pa", iss_pa, 0);
      chk("rst_free_cnt", free_cnt, DEPTH);
      chk("rst_full_rs", full_rs, 0);
      tick;
      rst = 1'b1;
   endtask

   // ------------------------------------------------------- reference model
   typedef struct {
      logic       vld, ra, rb;
      logic [4:0] pa, pb, pw, rob;
   } ment_t;

   ment_t      m_q [DEPTH];
   logic       m_iv;
   logic [4:0] m_pa, m_pb, m_pw, m_rob;

   function automatic bit wb_match(input logic [4:0] tag);
      for (int c = 0; c < N_WB; c++)
         if (wb_valid[c] && wb_preg[c*PREG_W +: PREG_W] == tag) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int model_free();
      int n = 0;
      for (int i = 0; i < DEPTH; i++) if (!m_q[i].vld) n++;
      return n;
   endfunction

   task automatic model_reset;
      for (int i = 0; i < DEPTH; i++) m_q[i] = '{default: '0};
      m_iv = 1'b0;
   endtask

   task automatic model_step;
      ment_t nq [DEPTH];
      int    free_list [$];
      int    best, best_age, age, e;
      nq = m_q;
      for (int i = 0; i < DEPTH; i++) if (!m_q[i].vld) free_list.push_back(i);
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) nq[i].vld = 1'b0;
         m_iv = 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (m_q[i].vld) begin
               if (wb_match(m_q[i].pa)) nq[i].ra = 1'b1;
               if (wb_match(m_q[i].pb)) nq[i].rb = 1'b1;
            end
         end
         if (!m_iv || iss_ready) begin
            best = -1;
            best_age = 0;
            for (int i = 0; i < DEPTH; i++) begin
               if (m_q[i].vld && m_q[i].ra && m_q[i].rb) begin
                  age = (int'(m_q[i].rob) - int'(ptr_old) + 32) % 32;
                  if (best < 0 || age < best_age) begin
                     best = i;
                     best_age = age;
                  end
               end
            end
            if (best >= 0) begin
               m_iv  = 1'b1;
               m_pa  = m_q[best].pa;
               m_pb  = m_q[best].pb;
               m_pw  = m_q[best].pw;
               m_rob = m_q[best].rob;
               nq[best].vld = 1'b0;
            end else begin
               m_iv = 1'b0;
            end
         end
         if (disp_en && free_list.size() >= N_DISP) begin
            for (int p = 0; p < N_DISP; p++) begin
               if (disp_valid[p] && disp_type[p*TYPE_W +: TYPE_W] == type_ref) begin
                  e = free_list.pop_front();
                  nq[e].vld = 1'b1;
                  nq[e].pa  = disp_pa[p*PREG_W +: PREG_W];
                  nq[e].pb  = disp_pb[p*PREG_W +: PREG_W];
                  nq[e].pw  = disp_pw[p*PREG_W +: PREG_W];
                  nq[e].rob = disp_rob[p*ROB_W +: ROB_W];
                  nq[e].ra  = disp_ra[p] | wb_match(nq[e].pa);
                  nq[e].rb  = disp_rb[p] | wb_match(nq[e].pb);
               end
            end
         end
      end
      m_q = nq;
   endtask

   task automatic rand_inputs;
      clear_in;
      disp_en = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < N_DISP; p++) begin
         if ($urandom_range(0, 1) == 1) begin
            set_port(p, 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                     5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) == 0) disp_type[p*TYPE_W +: TYPE_W] = 2'($urandom_range(0, 3));
         end
      end
      for (int c = 0; c < N_WB; c++)
         if ($urandom_range(0, 2) == 0) set_wb(c, 5'($urandom_range(0, 15)));
      iss_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) ptr_old = 5'($urandom_range(0, 31));
   endtask

   // ------------------------------------------------------------ step table
   typedef struct {
      logic        en;
      logic [2:0]  vld;
      logic [2:0]  rdy;
      logic [14:0] rob;
      logic        rdy_i;
      logic        fl;
      logic        e_iv;
      logic [4:0]  e_rob;
      logic [3:0]  e_free;
      logic        e_full;
   } vec_t;

   vec_t tbl [9];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      type_ref = TREF;
      clear_in;
      ptr_old = '0;

      tbl[0] = '{1'b1, 3'b111, 3'b111, {5'd6, 5'd5, 5'd4},    1'b1, 1'b0, 1'b0, 5'd0,  4'd5, 1'b0};
      tbl[1] = '{1'b0, 3'b000, 3'b000, 15'd0,                  1'b1, 1'b0, 1'b1, 5'd4,  4'd6, 1'b0};
      tbl[2] = '{1'b0, 3'b000, 3'b000, 15'd0,                  1'b1, 1'b0, 1'b1, 5'd5,  4'd7, 1'b0};
      tbl[3] = '{1'b0, 3'b000, 3'b000, 15'd0,                  1'b1, 1'b0, 1'b1, 5'd6,  4'd8, 1'b0};
      tbl[4] = '{1'b0, 3'b000, 3'b000, 15'd0,                  1'b1, 1'b0, 1'b0, 5'd0,  4'd8, 1'b0};
      tbl[5] = '{1'b1, 3'b111, 3'b111, {5'd12, 5'd11, 5'd10}, 1'b1, 1'b0, 1'b0, 5'd0,  4'd5, 1'b0};
      tbl[6] = '{1'b1, 3'b111, 3'b111, {5'd15, 5'd14, 5'd13}, 1'b1, 1'b0, 1'b1, 5'd10, 4'd3, 1'b0};
      tbl[7] = '{1'b1, 3'b111, 3'b111, {5'd22, 5'd21, 5'd20}, 1'b1, 1'b1, 1'b0, 5'd0,  4'd8, 1'b0};
      tbl[8] = '{1'b0, 3'b000, 3'b000, 15'd0,                  1'b1, 1'b0, 1'b0, 5'd0,  4'd8, 1'b0};

      do_reset;
      for (int s = 0; s < 9; s++) begin
         clear_in;
         disp_en   = tbl[s].en;
         iss_ready = tbl[s].rdy_i;
         flush     = tbl[s].fl;
         for (int p = 0; p < N_DISP; p++)
            if (tbl[s].vld[p])
               set_port(p, 5'(8+p), 5'(16+p), 5'(24+p), tbl[s].rob[p*5 +: 5], tbl[s].rdy[p], tbl[s].rdy[p]);
         tick;
         chk($sformatf("tbl%0d_iss_valid", s), iss_valid, tbl[s].e_iv);
         if (tbl[s].e_iv) chk($sformatf("tbl%0d_iss_rob", s), iss_rob, tbl[s].e_rob);
         chk($sformatf("tbl%0d_free_cnt", s), free_cnt, tbl[s].e_free);
         chk($sformatf("tbl%0d_full_rs", s), full_rs, tbl[s].e_full);
      end

      // Fill to capacity, overflow group ignored, wakeups drain one at a time
      do_reset;
      set_port(0, 5'd7,  5'd1, 5'd10, 5'd0, 1'b0, 1'b1);
      set_port(1, 5'd20, 5'd1, 5'd11, 5'd1, 1'b0, 1'b1);
      set_port(2, 5'd21, 5'd1, 5'd12, 5'd2, 1'b0, 1'b1);
      disp_en = 1'b1;
      tick;
      chk("full_g1_free", free_cnt, 5);
      clear_in;
      set_port(0, 5'd22, 5'd1, 5'd13, 5'd3, 1'b0, 1'b1);
      set_port(1, 5'd23, 5'd1, 5'd14, 5'd4, 1'b0, 1'b1);
      disp_en = 1'b1;
      tick;
      chk("full_g2_free", free_cnt, 3);
      chk("full_g2_full", full_rs, 0);
      clear_in;
      set_port(0, 5'd24, 5'd1, 5'd15, 5'd5, 1'b0, 1'b1);
      set_port(1, 5'd25, 5'd1, 5'd16, 5'd6, 1'b0, 1'b1);
      set_port(2, 5'd26, 5'd1, 5'd17, 5'd7, 1'b0, 1'b1);
      disp_en = 1'b1;
      tick;
      chk("full_g3_free", free_cnt, 0);
      chk("full_g3_full", full_rs, 1);
      clear_in;
      set_port(0, 5'd2, 5'd3, 5'd18, 5'd8,  1'b1, 1'b1);
      set_port(1, 5'd2, 5'd3, 5'd19, 5'd9,  1'b1, 1'b1);
      set_port(2, 5'd2, 5'd3, 5'd20, 5'd10, 1'b1, 1'b1);
      disp_en = 1'b1;
      tick;
      chk("full_ovf_free", free_cnt, 0);
      chk("full_ovf_full", full_rs, 1);
      clear_in;
      set_wb(1, 5'd7);
      tick;
      chk("full_wb7_iss_valid", iss_valid, 0);
      chk("full_wb7_free", free_cnt, 0);
      clear_in;
      tick;
      chk("full_iss0_valid", iss_valid, 1);
      chk("full_iss0_rob", iss_rob, 0);
      chk("full_iss0_free", free_cnt, 1);
      chk("full_iss0_full", full_rs, 1);
      clear_in;
      set_wb(0, 5'd20);
      tick;
      chk("full_wb20_iss_valid", iss_valid, 0);
      clear_in;
      tick;
      chk("full_iss1_rob", iss_rob, 1);
      chk("full_iss1_free", free_cnt, 2);
      chk("full_iss1_full", full_rs, 1);
      clear_in;
      set_wb(2, 5'd21);
      tick;
      clear_in;
      tick;
      chk("full_iss2_rob", iss_rob, 2);
      chk("full_iss2_free", free_cnt, 3);
      chk("full_iss2_full", full_rs, 0);

      // Same-cycle wakeup of a dispatching source
      do_reset;
      set_port(0, 5'd9, 5'd3, 5'd12, 5'd3, 1'b0, 1'b1);
      set_wb(2, 5'd9);
      disp_en = 1'b1;
      tick;
      chk("byp_t1_iss_valid", iss_valid, 0);
      clear_in;
      tick;
      chk("byp_t2_iss_valid", iss_valid, 1);
      chk("byp_t2_iss_rob", iss_rob, 3);
      chk("byp_t2_iss_pa", iss_pa, 9);
      chk("byp_t2_iss_pw", iss_pw, 12);

      // ROB wrap: head at 30, so 31 is oldest, then 1, then 2
      do_reset;
      ptr_old = 5'd30;
      set_port(0, 5'd1, 5'd2, 5'd3, 5'd1,  1'b1, 1'b1);
      set_port(1, 5'd1, 5'd2, 5'd4, 5'd31, 1'b1, 1'b1);
      set_port(2, 5'd1, 5'd2, 5'd5, 5'd2,  1'b1, 1'b1);
      disp_en = 1'b1;
      tick;
      clear_in;
      tick;
      chk("wrap_first", iss_rob, 31);
      tick;
      chk("wrap_second", iss_rob, 1);
      tick;
      chk("wrap_third", iss_rob, 2);

      // Back-pressure holds the issue register and the queue
      do_reset;
      set_port(0, 5'd4, 5'd1, 5'd6, 5'd8, 1'b1, 1'b1);
      set_port(1, 5'd5, 5'd1, 5'd7, 5'd9, 1'b1, 1'b1);
      disp_en = 1'b1;
      tick;
      chk("hold_disp_free", free_cnt, 6);
      clear_in;
      iss_ready = 1'b0;
      tick;
      chk("hold_load_rob", iss_rob, 8);
      chk("hold_load_free", free_cnt, 7);
      for (int k = 0; k < 5; k++) begin
         tick;
         chk($sformatf("hold%0d_valid", k), iss_valid, 1);
         chk($sformatf("hold%0d_rob", k), iss_rob, 8);
         chk($sformatf("hold%0d_pa", k), iss_pa, 4);
         chk($sformatf("hold%0d_free", k), free_cnt, 7);
      end
      iss_ready = 1'b1;
      tick;
      chk("hold_rel_rob", iss_rob, 9);
      chk("hold_rel_pa", iss_pa, 5);
      chk("hold_rel_free", free_cnt, 8);

      // Asynchronous reset pulse in the middle of a cycle
      do_reset;
      set_port(0, 5'd1, 5'd2, 5'd3, 5'd3, 1'b1, 1'b1);
      set_port(1, 5'd1, 5'd2, 5'd4, 5'd4, 1'b1, 1'b1);
      disp_en = 1'b1;
      tick;
      clear_in;
      tick;
      chk("arst_pre_valid", iss_valid, 1);
      #2 rst = 1'b0;
      #1;
      chk("arst_iss_valid", iss_valid, 0);
      chk("arst_iss_rob", iss_rob, 0);
      chk("arst_free", free_cnt, 8);
      #2 rst = 1'b1;
      tick;
      chk("arst_after_valid", iss_valid, 0);
      chk("arst_after_free", free_cnt, 8);

      // Random traffic against the model
      do_reset;
      model_reset;
      for (int n = 0; n < 1500; n++) begin
         rand_inputs;
         model_step;
         tick;
         chk("rnd_iss_valid", iss_valid, m_iv);
         if (m_iv) begin
            chk("rnd_iss_rob", iss_rob, m_rob);
            chk("rnd_iss_pa", iss_pa, m_pa);
            chk("rnd_iss_pb", iss_pb, m_pb);
            chk("rnd_iss_pw", iss_pw, m_pw);
         end
         chk("rnd_free_cnt", free_cnt, model_free());
         chk("rnd_full_rs", full_rs, (model_free() < N_DISP));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/issue_queue.md
# issue_queue

Parametrised reservation station / issue queue for one functional-unit class in the out-of-order back end. It sits between rename/dispatch and the execute stage. Each cycle it accepts up to N_DISP renamed micro-ops, snoops N_WB writeback broadcast channels to mark physical source operands ready, and issues the oldest fully-ready entry (relative to the ROB head) through a registered valid/ready output port.

## Interface
Parameters:
- DEPTH, 8: number of entries; power of two, 4..32.
- N_DISP, 3: dispatch ports per cycle.
- N_WB, 3: writeback broadcast channels.
- PREG_W, 5: physical register tag width.
- ROB_W, 5: ROB tag width.
- TYPE_W, 2: micro-op class field width.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of every entry and the issue register.
- type_ref  in  TYPE_W  class this instance accepts.
- disp_en  in  1  dispatch group valid; equivalent to valid_pc && !freeze_front.
- disp_valid  in  N_DISP  per-port micro-op valid.
- disp_type  in  N_DISP*TYPE_W  per-port class.
- disp_pa, disp_pb, disp_pw  in  N_DISP*PREG_W  source A, source B and destination tags.
- disp_ra, disp_rb  in  N_DISP  source ready at rename.
- disp_rob  in  N_DISP*ROB_W  ROB tag.
- full_rs  out  1  free entries < N_DISP.
- free_cnt  out  $clog2(DEPTH+1)  count of free entries.
- wb_valid  in  N_WB  broadcast valid; caller pre-qualifies, e.g. load-only for LS.
- wb_preg  in  N_WB*PREG_W  broadcast destination tag.
- ptr_old  in  ROB_W  ROB head tag.
- iss_valid  out  1  issue register holds a micro-op.
- iss_ready  in  1  execute stage accepts.
- iss_pa, iss_pb, iss_pw  out  PREG_W  issued tags.
- iss_rob  out  ROB_W  issued ROB tag.

## Operation
- Entry state: vld, rdy_a, rdy_b, pa, pb, pw, rob.
- Reset, rst=0, asynchronous: all vld/rdy cleared, iss_valid=0, all iss_* fields = 0. free_cnt=DEPTH, full_rs=0 (N_DISP <= DEPTH).
- Accept condition: disp_en && !full_rs && !flush. A port writes an entry when disp_valid[i] && disp_type[i]==type_ref.
  - Accepted ports take the lowest-index free entries in ascending port order. Free status is taken from the current registered state.
  - If disp_en=1 while full_rs=1, the whole group is ignored. Upstream must stall.
- Dispatch bypass: the source ready bit is set when disp_r* is 1, or when the source tag matches any wb_valid channel in the same cycle.
- Wakeup: for each vld entry, a source matching any valid wb channel gets its rdy bit set at the edge. Sticky until the entry frees.
- Select: candidates are entries with vld&rdy_a&rdy_b. Age = (rob - ptr_old) mod 2^ROB_W. Smallest age wins; ties go to the lowest index. Implement as a log2(DEPTH) comparator tree.
- Issue register loads when (!iss_valid || iss_ready) and a candidate exists. The selected entry's vld is cleared at the same edge.
  - When the register is free but there is no candidate, iss_valid is cleared.
  - When iss_valid && !iss_ready, the register holds and no entry is freed.
- flush: all entries and iss_valid are cleared next edge. Flush takes priority over dispatch, wakeup and issue.

## Timing
- Dispatch at cycle t: the entry is visible at t+1. The earliest issue selection is t+1, with iss_valid at t+2.
- Broadcast at t: the dependent entry can be selected at t+1. Back-to-back dependent issue gap is 1 cycle.
- An entry freed at edge t+1 is reusable by dispatch in cycle t+1. free_cnt and full_rs are registered-state functions and are not affected by the same-cycle dispatch.
- Simultaneous events: dispatch plus issue in one cycle is allowed. Wakeup plus dispatch to the same tag sets the bit via bypass. Multiple wb channels hitting one source set it once.
- ROB wrap: age compare is modular, so tag 0 is younger than tag 31 when ptr_old=30 (ROB_W=5).
- rst deasserted mid-operation: the queue is empty on the first cycle, with no spurious iss_valid.

## Test plan
- Reset then dispatch 3 ready ops with rob 4,5,6 -> iss_valid on cycles +2,+3,+4 with iss_rob 4,5,6; free_cnt returns to 8.
- Fill 8 entries with unready sources -> full_rs=1 and free_cnt=0. A 9th dispatch with disp_en=1 is ignored. A broadcast of pa tag 7 frees one entry two cycles later, and full_rs drops only once free_cnt >= 3.
- Dispatch an op with pa=9 unready while wb_preg[2]=9 is valid in the same cycle -> issued at +2 with no extra wait.
- ptr_old=30, ready entries with rob 1, 31, 2 -> issue order 31, 1, 2.
- Hold iss_ready=0 for 5 cycles with 2 ready entries -> iss_* stable and free_cnt unchanged. iss_ready=1 then issues the second entry the next cycle.
- flush asserted together with dispatch and issue -> next cycle iss_valid=0, free_cnt=8, dispatched ops absent. Async rst pulse mid-cycle clears outputs immediately.
